vedic_mul_arbiter: RTL
======================

// Module: vedic_mul_arbiter
// PURPOSE
//  Shares one signed 9x9 Vedic multiplier core (sign-magnitude wrapper around vedic_8X8,
//  17-bit signed product) among NREQ requesters. Round-robin grant, valid/ready on each
//  request port and on the single response port.
//  Patches core corner cases: zero product and the unsupported operand -256.
//  Sits between DSP/MAC clients and the combinational multiplier core.
// PARAMETERS
//  NREQ  4  number of requester ports (2..8)
//  IDW   2  requester-id width, = clog2(NREQ)
// PORTS
//  clk       in   1        clock, rising edge
//  rst       in   1        asynchronous reset, active-high
//  req_valid in   NREQ     per-requester operand valid
//  req_ready out  NREQ     per-requester accept; one-hot or zero
//  req_a     in   9*NREQ   signed operand A; requester i uses [9*i+8:9*i]
//  req_b     in   9*NREQ   signed operand B; same packing as req_a
//  rsp_valid out  1        product valid
//  rsp_ready in   1        consumer accepts product
//  rsp_id    out  IDW      index of requester that owns rsp_p
//  rsp_p     out  17       signed product a*b
//  rsp_err   out  1        an operand was -256 (9'h100); rsp_p forced to 0
//  busy      out  1        FSM not in IDLE
// BEHAVIOUR
//  Reset values: rsp_valid=0, rsp_id=0, rsp_p=0, rsp_err=0, busy=0, req_ready=0,
//   FSM=IDLE, rr_ptr=0.
//  FSM states:
//   IDLE
//    - req_ready = one-hot round-robin winner among req_valid.
//    - Search starts at rr_ptr and wraps NREQ-1 -> 0.
//    - With no req_valid, stay in IDLE.
//    - On handshake with winner w: latch a, b and w into op_a, op_b, op_id;
//      set rr_ptr = (w+1) mod NREQ; go to CALC.
//   CALC
//    - req_ready=0; the core is driven from op_a/op_b.
//    - At the clock edge: register the result into rsp_p, rsp_id=op_id, rsp_valid=1;
//      go to RESP.
//   RESP
//    - Hold rsp_* stable while rsp_ready=0.
//    - On rsp_valid&&rsp_ready: rsp_valid=0; go to IDLE.
//  Timing and throughput:
//   - Request handshake at cycle T -> rsp_valid high from cycle T+2.
//   - Maximum throughput is 1 product per 3 cycles.
//   - req_ready is a combinational function of state, rr_ptr and req_valid.
//   - req_ready never depends on rsp_ready.
//  Result rules, checked in order:
//   1. op_a==9'h100 or op_b==9'h100: rsp_err=1, rsp_p=0.
//   2. op_a==0 or op_b==0: rsp_err=0, rsp_p=0. This overrides the core, which
//      returns 17'h10000 for zero with mixed signs.
//   3. Otherwise: rsp_err=0, rsp_p = core output = sign-extended exact a*b,
//      range -65025..65025.
//  Boundary conditions:
//   - A request deasserting req_valid in IDLE before the handshake is not granted.
//   - A requester keeps req_valid asserted until it sees req_ready.
//   - Requests arriving in CALC/RESP wait; no queueing.
//   - Async rst mid-CALC/RESP: the in-flight product is dropped and all outputs
//     return to reset values.
//   - rsp_ready asserted while rsp_valid=0 is ignored.
// TESTING
//  1. Single req 0, a=9'sd100, b=-9'sd25, rsp_ready=1
//     -> rsp_valid at T+2, rsp_p=-2500, rsp_id=0, rsp_err=0; 1-cycle pulse.
//  2. All 4 req_valid held with distinct operands
//     -> grant order 0,1,2,3,0; each rsp_id matches; one grant per 3 cycles.
//  3. a=0, b=-9'sd7 -> rsp_p=0 (not 17'h10000). a=255, b=-255 -> rsp_p=-65025.
//  4. a=9'h100, b=3 -> rsp_err=1, rsp_p=0; next request a=2, b=2 -> rsp_err=0, rsp_p=4.
//  5. rsp_ready=0 for 5 cycles with req 1 valid
//     -> rsp_* stable, req_ready stays 0, busy=1; on release, req 1 granted next IDLE cycle.
//  6. rst asserted in CALC -> outputs at reset values immediately (async);
//     after release, a fresh request yields a correct product.
//  Scoreboard: random a,b in [-255,255] on random requesters vs a*b, over 10k ops.

Source files
------------

// File: rtl/vedic_mul_arbiter.sv
// Round-robin arbiter sharing one signed 9x9 Vedic multiplier among NREQ requesters.
// Latency: request handshake at cycle T -> rsp_valid from T+2; one product per 3 cycles.
// Backpressure: rsp_ready low holds rsp_* and the FSM in RESP; req_ready stays 0 until IDLE.
module vedic_mul_arbiter #(
   parameter int NREQ = 4,
   parameter int IDW  = $clog2(NREQ)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NREQ-1:0]   req_valid,
   output logic [NREQ-1:0]   req_ready,
   input  logic [9*NREQ-1:0] req_a,
   input  logic [9*NREQ-1:0] req_b,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [IDW-1:0]    rsp_id,
   output logic [16:0]       rsp_p,
   output logic              rsp_err,
   output logic              busy
);

   typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

   state_t          state, state_n;
   logic [IDW-1:0]  rr_ptr;
   logic [IDW-1:0]  rr_next;
   logic [IDW:0]    rr_idx;
   logic [NREQ-1:0] grant;
   logic [IDW-1:0]  win;
   logic            found;
   logic [8:0]      sel_a, sel_b;
   logic [8:0]      op_a, op_b;
   logic [IDW-1:0]  op_id;
   logic [7:0]      mag_a, mag_b;
   logic [15:0]     mag_p;
   logic            neg_sign;
   logic [16:0]     core_p;
   logic [16:0]     res_p;
   logic            res_err;

   // 2x2 Urdhva-Tiryagbhyam cell: vertical and crosswise partial products.
   function automatic logic [3:0] vedic_2x2(input logic [1:0] a, input logic [1:0] b);
      logic       c;
      logic [3:0] p;
      c    = (a[1] & b[0]) & (a[0] & b[1]);
      p[0] = a[0] & b[0];
      p[1] = (a[1] & b[0]) ^ (a[0] & b[1]);
      p[2] = (a[1] & b[1]) ^ c;
      p[3] = (a[1] & b[1]) & c;
      return p;
   endfunction

   function automatic logic [7:0] vedic_4x4(input logic [3:0] a, input logic [3:0] b);
      logic [3:0] ll, lh, hl, hh;
      ll = vedic_2x2(a[1:0], b[1:0]);
      lh = vedic_2x2(a[1:0], b[3:2]);
      hl = vedic_2x2(a[3:2], b[1:0]);
      hh = vedic_2x2(a[3:2], b[3:2]);
      return {4'b0000, ll} + {2'b00, lh, 2'b00} + {2'b00, hl, 2'b00} + {hh, 4'b0000};
   endfunction

   function automatic logic [15:0] vedic_8x8(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] ll, lh, hl, hh;
      ll = vedic_4x4(a[3:0], b[3:0]);
      lh = vedic_4x4(a[3:0], b[7:4]);
      hl = vedic_4x4(a[7:4], b[3:0]);
      hh = vedic_4x4(a[7:4], b[7:4]);
      return {8'h00, ll} + {4'h0, lh, 4'h0} + {4'h0, hl, 4'h0} + {hh, 8'h00};
   endfunction

   // Round-robin search starting at rr_ptr, wrapping NREQ-1 -> 0; first valid wins.
   always_comb begin
      grant  = '0;
      win    = '0;
      found  = 1'b0;
      rr_idx = '0;
      for (int i = 0; i < NREQ; i++) begin
         rr_idx = {1'b0, rr_ptr} + (IDW+1)'(i);
         if (rr_idx >= (IDW+1)'(NREQ)) begin
            rr_idx = rr_idx - (IDW+1)'(NREQ);
         end
         if (!found && req_valid[rr_idx[IDW-1:0]]) begin
            found                     = 1'b1;
            win                       = rr_idx[IDW-1:0];
            grant[rr_idx[IDW-1:0]]    = 1'b1;
         end
      end
   end

   assign rr_next = (win == IDW'(NREQ-1)) ? '0 : win + IDW'(1);

   // Operand mux driven by the one-hot grant so no variable part-select is needed.
   always_comb begin
      sel_a = '0;
      sel_b = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (grant[i]) begin
            sel_a = req_a[9*i +: 9];
            sel_b = req_b[9*i +: 9];
         end
      end
   end

   // Sign-magnitude core plus the zero / -256 result patches.
   always_comb begin
      mag_a    = op_a[8] ? (8'd0 - op_a[7:0]) : op_a[7:0];
      mag_b    = op_b[8] ? (8'd0 - op_b[7:0]) : op_b[7:0];
      mag_p    = vedic_8x8(mag_a, mag_b);
      neg_sign = op_a[8] ^ op_b[8];
      // Negating a zero magnitude leaves the sign bit set (17'h10000); patched below.
      core_p   = neg_sign ? {1'b1, (~mag_p) + 16'd1} : {1'b0, mag_p};
      res_err  = 1'b0;
      res_p    = core_p;
      if (op_a == 9'h100 || op_b == 9'h100) begin
         res_err = 1'b1;
         res_p   = '0;
      end else if (op_a == 9'h000 || op_b == 9'h000) begin
         res_p   = '0;
      end
   end

   // FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_n;
      end
   end

   // FSM next state and request-side outputs; req_ready never looks at rsp_ready.
   always_comb begin
      state_n   = state;
      req_ready = '0;
      busy      = 1'b1;
      unique case (state)
         IDLE: begin
            busy      = 1'b0;
            req_ready = grant;
            if (found) begin
               state_n = CALC;
            end
         end
         CALC: begin
            state_n = RESP;
         end
         RESP: begin
            if (rsp_valid && rsp_ready) begin
               state_n = IDLE;
            end
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   // Operand capture on grant, result register in CALC, release on response handshake.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_a      <= '0;
         op_b      <= '0;
         op_id     <= '0;
         rr_ptr    <= '0;
         rsp_valid <= 1'b0;
         rsp_id    <= '0;
         rsp_p     <= '0;
         rsp_err   <= 1'b0;
      end else begin
         if (state == IDLE && found) begin
            op_a   <= sel_a;
            op_b   <= sel_b;
            op_id  <= win;
            rr_ptr <= rr_next;
         end
         if (state == CALC) begin
            rsp_p     <= res_p;
            rsp_err   <= res_err;
            rsp_id    <= op_id;
            rsp_valid <= 1'b1;
         end
         if (state == RESP && rsp_valid && rsp_ready) begin
            rsp_valid <= 1'b0;
         end
      end
   end

endmodule
